// File: rtl/up_sample_nn_affine_controller.sv
// Affine loop-nest controller for the up_sample nearest-neighbour op: start delay,
// then an odometer walk over (d0,d1,d2) at a fixed initiation interval, then done.
module up_sample_nn_affine_controller #(
    parameter int START_DELAY = 4,
    parameter int II          = 1,
    parameter int EXTENT_0    = 1,
    parameter int EXTENT_1    = 128,
    parameter int EXTENT_2    = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        stall,
    output logic        valid,
    output logic [15:0] d [2:0],
    output logic        done
);

    typedef enum logic [1:0] {
        ST_DELAY = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int EXT [3] = '{EXTENT_0, EXTENT_1, EXTENT_2};

    state_t      state_reg, state_next;
    logic [15:0] delay_cnt_reg, delay_cnt_next;
    logic [7:0]  ii_cnt_reg, ii_cnt_next;
    logic [15:0] d_reg [2:0];
    logic [15:0] d_next [2:0];
    logic [2:0]  at_max;
    logic        fire;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_max
            assign at_max[gi] = (d_reg[gi] == 16'(EXT[gi] - 1));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_DELAY;
            delay_cnt_reg <= '0;
            ii_cnt_reg    <= '0;
            d_reg[0]      <= '0;
            d_reg[1]      <= '0;
            d_reg[2]      <= '0;
        end else begin
            state_reg     <= state_next;
            delay_cnt_reg <= delay_cnt_next;
            ii_cnt_reg    <= ii_cnt_next;
            d_reg[0]      <= d_next[0];
            d_reg[1]      <= d_next[1];
            d_reg[2]      <= d_next[2];
        end
    end

    // flush overrides everything, including a fire presented in the same cycle
    always_comb begin
        state_next     = state_reg;
        delay_cnt_next = delay_cnt_reg;
        ii_cnt_next    = ii_cnt_reg;
        d_next[0]      = d_reg[0];
        d_next[1]      = d_reg[1];
        d_next[2]      = d_reg[2];
        if (flush) begin
            state_next     = ST_DELAY;
            delay_cnt_next = '0;
            ii_cnt_next    = '0;
            d_next[0]      = '0;
            d_next[1]      = '0;
            d_next[2]      = '0;
        end else begin
            case (state_reg)
                ST_DELAY: begin
                    delay_cnt_next = delay_cnt_reg + 16'd1;
                    if (delay_cnt_reg == 16'(START_DELAY)) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fire) begin
                        ii_cnt_next = (II > 1) ? 8'd1 : 8'd0;
                        if (&at_max) begin
                            state_next = ST_DONE;
                        end else begin
                            d_next[2] = at_max[2] ? 16'd0 : d_reg[2] + 16'd1;
                            if (at_max[2]) begin
                                d_next[1] = at_max[1] ? 16'd0 : d_reg[1] + 16'd1;
                                if (at_max[1]) begin
                                    d_next[0] = d_reg[0] + 16'd1;
                                end
                            end
                        end
                    end else if (!stall && ii_cnt_reg != 8'd0) begin
                        ii_cnt_next = (ii_cnt_reg == 8'(II - 1)) ? 8'd0 : ii_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_next = ST_DONE;
                end
            endcase
        end
    end

    always_comb begin
        fire  = (state_reg == ST_RUN) && (ii_cnt_reg == 8'd0) && !stall;
        valid = fire;
        done  = (state_reg == ST_DONE);
        d[0]  = d_reg[0];
        d[1]  = d_reg[1];
        d[2]  = d_reg[2];
    end

endmodule

// File: tb/tb_up_sample_nn_affine_controller.sv
// Scoreboard bench: four controller instances with different parameters run in parallel;
// expected fires (cycle, d) are queued by the stimulus and popped by per-instance monitors.
module tb_up_sample_nn_affine_controller;

    typedef struct {
        int          cyc;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] d2;
    } fire_t;

    localparam int SD_P [4] = '{3, 3, 3, 4};
    localparam int II_P [4] = '{1, 3, 2, 1};
    localparam int E0_P [4] = '{1, 1, 1, 1};
    localparam int E1_P [4] = '{2, 2, 2, 128};
    localparam int E2_P [4] = '{3, 3, 3, 128};

    logic       clk;
    logic       rst_n;
    logic [3:0] flush_v;
    logic [3:0] stall_v;
    logic [3:0] exp_done;
    logic [3:0] mon_en;
    int         cyc;
    int         checks;
    int         errors;
    fire_t      exp_q [4][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle k = interval after the k-th rising edge since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, id, cyc, act, expv);
        end
    endtask

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            logic        valid;
            logic        done;
            logic [15:0] dv [2:0];

            up_sample_nn_affine_controller #(
                .START_DELAY(SD_P[gi]),
                .II         (II_P[gi]),
                .EXTENT_0   (E0_P[gi]),
                .EXTENT_1   (E1_P[gi]),
                .EXTENT_2   (E2_P[gi])
            ) u_dut (
                .clk  (clk),
                .rst_n(rst_n),
                .flush(flush_v[gi]),
                .stall(stall_v[gi]),
                .valid(valid),
                .d    (dv),
                .done (done)
            );

            always @(negedge clk) begin
                fire_t e;
                if (mon_en[gi]) begin
                    if (!rst_n) begin
                        chk("reset_out", gi, {14'd0, valid, done, dv[0], dv[1], dv[2]}, 64'd0);
                    end else begin
                        chk("done", gi, 64'(done), 64'(exp_done[gi]));
                        if (valid) begin
                            if (exp_q[gi].size() == 0) begin
                                chk("extra_fire", gi, {16'(cyc), dv[0], dv[1], dv[2]}, 64'd0);
                            end else begin
                                e = exp_q[gi].pop_front();
                                $display("dut%0d fire cycle %0d d=(%0d,%0d,%0d)", gi, cyc, dv[0], dv[1], dv[2]);
                                chk("fire", gi, {16'(cyc), dv[0], dv[1], dv[2]},
                                    {16'(e.cyc), e.d0, e.d1, e.d2});
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    task automatic push(input int id, input int c, input int a, input int b, input int z);
        fire_t f;
        f.cyc = c;
        f.d0  = 16'(a);
        f.d1  = 16'(b);
        f.d2  = 16'(z);
        exp_q[id].push_back(f);
    endtask

    // first n points of the 1x2x3 nest, one every `step` cycles from `start`
    task automatic push_small(input int id, input int start, input int step, input int n);
        for (int i = 0; i < n; i++) begin
            push(id, start + i * step, 0, (i / 3) % 2, i % 3);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc != n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        flush_v  = '0;
        stall_v  = '0;
        exp_done = '0;
        mon_en   = 4'b1111;
        repeat (3) @(posedge clk);

        // dut0: basic run; dut1: II=3; dut2: II=2 with a stall; dut3: default 128x128
        push_small(0, 4, 1, 6);
        push_small(1, 4, 3, 6);
        push(2, 4, 0, 0, 0);
        push(2, 11, 0, 0, 1);
        push(2, 13, 0, 0, 2);
        push(2, 15, 0, 1, 0);
        push(2, 17, 0, 1, 1);
        push(2, 19, 0, 1, 2);
        for (int i = 0; i < 16384; i++) begin
            push(3, 5 + i, 0, i / 128, i % 128);
        end
        release_reset();

        wait_cyc(6);
        stall_v[2] = 1'b1;
        wait_cyc(10);
        exp_done[0] = 1'b1;
        wait_cyc(11);
        stall_v[2] = 1'b0;
        wait_cyc(20);
        exp_done[1] = 1'b1;
        exp_done[2] = 1'b1;

        // two-cycle flush out of DONE, then a flush on the fire of (0,1,0)
        wait_cyc(30);
        flush_v[0] = 1'b1;
        push(0, 36, 0, 0, 0);
        push(0, 37, 0, 0, 1);
        push(0, 38, 0, 0, 2);
        push(0, 39, 0, 1, 0);
        wait_cyc(31);
        exp_done[0] = 1'b0;
        wait_cyc(32);
        flush_v[0] = 1'b0;
        wait_cyc(39);
        flush_v[0] = 1'b1;
        push_small(0, 44, 1, 6);
        wait_cyc(40);
        flush_v[0] = 1'b0;
        wait_cyc(50);
        exp_done[0] = 1'b1;

        wait_cyc(16389);
        exp_done[3] = 1'b1;
        wait_cyc(16395);
        for (int i = 0; i < 4; i++) begin
            chk("leftover", i, 64'(exp_q[i].size()), 64'd0);
        end

        // asynchronous reset in the middle of a run on dut0
        rst_n    = 1'b0;
        exp_done = '0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 4'b0001;
        push_small(0, 4, 1, 2);
        rst_n = 1'b1;
        wait_cyc(6);
        chk("pre_reset", 0, {15'd0, g_dut[0].valid, g_dut[0].dv[0], g_dut[0].dv[1], g_dut[0].dv[2]},
            {15'd0, 1'b1, 16'd0, 16'd0, 16'd2});
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_drop", 0, {14'd0, g_dut[0].valid, g_dut[0].done, g_dut[0].dv[0], g_dut[0].dv[1], g_dut[0].dv[2]},
            64'd0);
        chk("leftover_rst", 0, 64'(exp_q[0].size()), 64'd0);
        repeat (2) @(posedge clk);
        push_small(0, 4, 1, 6);
        release_reset();
        wait_cyc(10);
        exp_done[0] = 1'b1;
        wait_cyc(12);
        chk("leftover_end", 0, 64'(exp_q[0].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
